// File: rtl/hamming_pkg.sv
// Shared widths, health encoding and the SEC-DED position map for the
// 22-bit codeword produced by the Hamming-protected counter stage.
package hamming_pkg;

  localparam int DATA_W = 16;
  localparam int CODE_W = 22;
  localparam int SYN_W  = 5;
  localparam logic [SYN_W-1:0] MAX_POS = 5'd21;

  typedef enum logic [1:0] {
    H_OK    = 2'b00,
    H_DEG   = 2'b01,
    H_FAULT = 2'b10
  } health_t;

  // Each mask selects the positions whose index has bit k set.
  function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] code);
    logic [SYN_W-1:0] s;
    s[0] = ^(code & 22'h2AAAAA);
    s[1] = ^(code & 22'h0CCCCC);
    s[2] = ^(code & 22'h30F0F0);
    s[3] = ^(code & 22'h00FF00);
    s[4] = ^(code & 22'h3F0000);
    return s;
  endfunction

  // data[0..15] sit at the non-power-of-two positions, ascending.
  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] code);
    return {code[21], code[20], code[19], code[18], code[17],
            code[15], code[14], code[13], code[12], code[11], code[10], code[9],
            code[7],  code[6],  code[5],  code[3]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall parity of one codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SYN_W-1:0]  syn_o,
  output logic              par_o
);

  assign syn_o = syndrome(code_i);
  assign par_o = ^code_i;

endmodule

// File: rtl/hamming_secded_checker.sv
// Two-stage SEC-DED decoder with saturating error counters and a sticky
// health state; stage 1 captures syndrome/parity, stage 2 corrects and flags.
module hamming_secded_checker
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  input  logic              clr_alarm,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic [1:0]        health
);

  logic [SYN_W-1:0]  syn_c;
  logic              par_c;

  logic [1:0]        vld_pipe_q;
  logic [CODE_W-1:0] code1_q;
  logic [SYN_W-1:0]  syn1_q;
  logic              par1_q;

  logic [DATA_W-1:0] data_q, data_d;
  logic              sec_q, sec_d;
  logic              ded_q, ded_d;
  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;
  health_t           state_q, state_d;

  logic [CODE_W-1:0] flip_c;

  hamming_syndrome u_syn (
    .code_i (in_code),
    .syn_o  (syn_c),
    .par_o  (par_c)
  );

  // stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q[0] <= 1'b0;
      code1_q       <= '0;
      syn1_q        <= '0;
      par1_q        <= 1'b0;
    end else begin
      vld_pipe_q[0] <= in_valid;
      if (in_valid) begin
        code1_q <= in_code;
        syn1_q  <= syn_c;
        par1_q  <= par_c;
      end
    end
  end

  // s = 0 with P = 1 means bit 0 itself flipped: nothing to repair in data.
  always_comb begin
    flip_c = '0;
    if (par1_q && syn1_q != '0 && syn1_q <= MAX_POS)
      flip_c = {{(CODE_W-1){1'b0}}, 1'b1} << syn1_q;
    sec_d  = vld_pipe_q[0] & par1_q & (syn1_q <= MAX_POS);
    ded_d  = vld_pipe_q[0] & ((par1_q & (syn1_q > MAX_POS)) |
                              (~par1_q & (syn1_q != '0)));
    data_d = vld_pipe_q[0] ? extract(code1_q ^ flip_c) : data_q;
    sec_cnt_d = (sec_d && sec_cnt_q != '1) ? sec_cnt_q + 1'b1 : sec_cnt_q;
    ded_cnt_d = (ded_d && ded_cnt_q != '1) ? ded_cnt_q + 1'b1 : ded_cnt_q;
  end

  // stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q[1] <= 1'b0;
      data_q        <= '0;
      sec_q         <= 1'b0;
      ded_q         <= 1'b0;
      sec_cnt_q     <= '0;
      ded_cnt_q     <= '0;
    end else begin
      vld_pipe_q[1] <= vld_pipe_q[0];
      data_q        <= data_d;
      sec_q         <= sec_d;
      ded_q         <= ded_d;
      sec_cnt_q     <= sec_cnt_d;
      ded_cnt_q     <= ded_cnt_d;
    end
  end

  // health FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= H_OK;
    else     state_q <= state_d;
  end

  // health FSM: next state; a new event always beats a coincident clear
  always_comb begin
    state_d = state_q;
    if (ded_d)
      state_d = H_FAULT;
    else if (sec_d)
      state_d = (clr_alarm || state_q == H_OK) ? H_DEG : state_q;
    else if (clr_alarm)
      state_d = H_OK;
  end

  // health FSM: outputs
  always_comb begin
    health = state_q;
  end

  assign out_valid = vld_pipe_q[1];
  assign out_data  = data_q;
  assign out_sec   = sec_q;
  assign out_ded   = ded_q;
  assign sec_count = sec_cnt_q;
  assign ded_count = ded_cnt_q;

endmodule

// File: tb/tb_hamming_secded_checker.sv
// Randomized bench with a behavioural SEC-DED model and a few literal
// expectations for the directed words, saturation and mid-flight reset.
module tb_hamming_secded_checker;
  import hamming_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [CODE_W-1:0] in_code = '0;
  logic              clr_alarm = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sec, out_ded;
  logic [7:0]        sec_count, ded_count;
  logic [1:0]        health;

  logic [CODE_W-1:0] enc_w = '0;
  logic [SYN_W-1:0]  enc_syn;
  logic              enc_par;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  always #5 clk = ~clk;

  hamming_secded_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .clr_alarm(clr_alarm), .out_valid(out_valid), .out_data(out_data),
    .out_sec(out_sec), .out_ded(out_ded), .sec_count(sec_count),
    .ded_count(ded_count), .health(health)
  );

  // encoder outputs must decode as clean words
  hamming_syndrome u_enc_chk (.code_i(enc_w), .syn_o(enc_syn), .par_o(enc_par));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_pow2(input int i);
    return (i & (i - 1)) == 0;
  endfunction

  function automatic logic [21:0] encode(input logic [15:0] d);
    logic [21:0] c;
    int j, s;
    c = '0; j = 0; s = 0;
    for (int i = 1; i < 22; i++)
      if (!is_pow2(i)) begin c[i] = d[j]; j++; end
    for (int i = 1; i < 22; i++) if (c[i]) s ^= i;
    for (int k = 0; k < 5; k++) if (s[k]) c[1 << k] = 1'b1;
    c[0] = ^c[21:1];
    return c;
  endfunction

  function automatic void mdecode(input logic [21:0] c, output logic [15:0] d,
                                  output bit sec, output bit ded);
    logic [21:0] cc;
    int s, ones, j;
    cc = c; s = 0; ones = 0; j = 0;
    sec = 0; ded = 0; d = '0;
    for (int i = 0; i < 22; i++)
      if (c[i]) begin ones++; if (i > 0) s ^= i; end
    if (ones % 2 == 1) begin
      if (s <= 21) begin sec = 1; if (s != 0) cc[s] = ~cc[s]; end
      else ded = 1;
    end else if (s != 0) ded = 1;
    for (int i = 1; i < 22; i++)
      if (!is_pow2(i)) begin d[j] = cc[i]; j++; end
  endfunction

  // behavioural model, advanced on every rising edge
  bit          p_v = 0;
  logic [21:0] p_code = '0;
  bit          m_valid = 0, m_sec = 0, m_ded = 0;
  logic [15:0] m_data = '0;
  int          m_secc = 0, m_dedc = 0, m_health = 0;

  always @(posedge clk) begin
    logic [15:0] d;
    bit s, e;
    if (rst) begin
      p_v = 0; m_valid = 0; m_sec = 0; m_ded = 0; m_data = '0;
      m_secc = 0; m_dedc = 0; m_health = 0;
    end else begin
      s = 0; e = 0;
      m_valid = p_v;
      if (p_v) begin
        mdecode(p_code, d, s, e);
        m_data = d;
      end
      m_sec = s; m_ded = e;
      if (s && m_secc < 255) m_secc++;
      if (e && m_dedc < 255) m_dedc++;
      if (e)              m_health = 2;
      else if (s)         m_health = (clr_alarm || m_health == 0) ? 1 : m_health;
      else if (clr_alarm) m_health = 0;
      p_v = in_valid; p_code = in_code;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data",  32'(out_data),  32'(m_data));
      chk("out_sec",   32'(out_sec),   32'(m_sec));
      chk("out_ded",   32'(out_ded),   32'(m_ded));
      chk("sec_count", 32'(sec_count), 32'(m_secc));
      chk("ded_count", 32'(ded_count), 32'(m_dedc));
      chk("health",    32'(health),    32'(m_health));
    end
  end

  // word enters at this negedge; returns at the negedge where it is at the output
  task automatic send(input logic [21:0] c, input bit clr_with);
    in_valid = 1'b1; in_code = c;
    @(negedge clk);
    in_valid = 1'b0; clr_alarm = clr_with;
    @(negedge clk);
    clr_alarm = 1'b0;
  endtask

  function automatic logic [21:0] flip1(input logic [21:0] c);
    logic [21:0] r;
    r = c;
    r[$urandom_range(0, 21)] ^= 1'b1;
    return r;
  endfunction

  initial begin
    logic [21:0] c;
    int a, b;
    @(negedge clk);
    run_cmp = 1;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst health", 32'(health), 0);
    chk("rst sec_count", 32'(sec_count), 0);
    rst = 1'b0;

    // model pins
    chk("enc 0001", 32'(encode(16'h0001)), 32'h00000F);
    chk("enc 0000", 32'(encode(16'h0000)), 0);

    send(22'h000000, 0);
    chk("zero valid", 32'(out_valid), 1);
    chk("zero data", 32'(out_data), 0);
    chk("zero flags", 32'({out_sec, out_ded}), 0);
    send(22'h00000F, 0);
    chk("d1 data", 32'(out_data), 32'h0001);
    chk("d1 flags", 32'({out_sec, out_ded}), 0);
    send(22'h000007, 0);
    chk("sec data", 32'(out_data), 32'h0001);
    chk("sec flag", 32'(out_sec), 1);
    chk("sec cnt", 32'(sec_count), 1);
    chk("sec health", 32'(health), 1);
    send(22'h000009, 0);
    chk("ded flag", 32'(out_ded), 1);
    chk("ded cnt", 32'(ded_count), 1);
    chk("ded health", 32'(health), 2);
    clr_alarm = 1'b1;
    @(negedge clk);
    clr_alarm = 1'b0;
    chk("clr health", 32'(health), 0);
    send(22'h000009, 1);
    chk("clr+ded health", 32'(health), 2);
    chk("clr+ded cnt", 32'(ded_count), 2);
    send(22'h000007, 1);
    chk("clr+sec health", 32'(health), 1);
    send(22'h010101, 0);
    chk("s>21 ded", 32'({out_sec, out_ded}), 32'b01);
    chk("s>21 data", 32'(out_data), 0);
    chk("s>21 health", 32'(health), 2);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      enc_w = encode(16'($urandom()));
      #1;
      chk("enc syndrome", 32'({enc_syn, enc_par}), 0);
      c = enc_w;
      case ($urandom_range(0, 3))
        1: c = flip1(c);
        2: begin
          a = $urandom_range(0, 21);
          b = (a + $urandom_range(1, 21)) % 22;
          c[a] ^= 1'b1; c[b] ^= 1'b1;
        end
        3: c = 22'($urandom());
        default: ;
      endcase
      in_valid = ($urandom_range(0, 3) != 0);
      in_code = c;
      clr_alarm = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; clr_alarm = 1'b0;

    // saturation from a clean reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 300; n++) begin
      in_valid = 1'b1;
      in_code = flip1(encode(16'($urandom())));
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sat sec_count", 32'(sec_count), 255);
    chk("sat ded_count", 32'(ded_count), 0);
    chk("sat health", 32'(health), 1);

    // reset while a word is in flight
    in_valid = 1'b1; in_code = 22'h000007;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk("flight out_valid", 32'(out_valid), 0);
      @(negedge clk);
    end
    chk("flight sec_count", 32'(sec_count), 0);
    chk("flight ded_count", 32'(ded_count), 0);
    chk("flight health", 32'(health), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
